controle_multiciclo: RTL and testbench

- Multicycle control FSM that sits directly upstream of the register bank.
- Generates `estado` plus the `regiwrite`/`memtoreg` strobes the bank consumes, and the IR/PC/memory/ALU controls for the rest of the datapath.
- Decodes the RV32I subset R-type, I-type ALU, lw, sw, beq/bne, and counts retired instructions.

---
 rtl/controle_multiciclo.sv | 189 ++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle RV32I-subset control FSM with retired-instruction counter.
// Optional `CONTROLE_STEP_EN` adds a `step` input that gates FETCH.
module controle_multiciclo #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef CONTROLE_STEP_EN
  input  logic               step,
`endif
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  output logic [3:0]         estado,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               pcsrc,
  output logic               memread,
  output logic               memwrite,
  output logic               alusrc,
  output logic [1:0]         aluop,
  output logic               regiwrite,
  output logic               memtoreg,
  output logic               halted,
  output logic [COUNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC     = 4'd3,
    MEM      = 4'd4,
    WB_ALU   = 4'd5,
    WB_MEM   = 4'd6,
    BRANCH   = 4'd7,
    HALT     = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LW   = 3'd3,
    C_SW   = 3'd4,
    C_BR   = 3'd5
  } cls_t;

  state_t             r_state;
  state_t             w_next;
  cls_t               r_cls;
  cls_t               w_cls;
  logic [2:0]         r_f3;
  logic [COUNT_W-1:0] r_instret;
  logic               w_go;
  logic               w_retire;
  logic               w_alu_ph;

`ifdef CONTROLE_STEP_EN
  assign w_go = step;
`else
  assign w_go = 1'b1;
`endif

  always_comb begin
    w_cls = C_NONE;
    case (opcode)
      7'b0110011: w_cls = C_R;
      7'b0010011: w_cls = C_I;
      7'b0000011: w_cls = C_LW;
      7'b0100011: w_cls = C_SW;
      7'b1100011: w_cls = C_BR;
      default:    w_cls = C_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_ST;
    end else begin
      r_state <= w_next;
    end
  end

  // Only the DECODE edge captures the instruction; later states use this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls <= C_NONE;
      r_f3  <= 3'd0;
    end else if (r_state == DECODE) begin
      r_cls <= w_cls;
      r_f3  <= funct3;
    end
  end

  assign w_retire = (r_state == WB_ALU) ||
                    (r_state == WB_MEM) ||
                    (r_state == BRANCH) ||
                    ((r_state == MEM) && (r_cls == C_SW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RESET_ST: w_next = FETCH;
      FETCH:    w_next = w_go ? DECODE : FETCH;
      DECODE:   w_next = (w_cls == C_NONE) ? HALT : EXEC;
      EXEC: begin
        unique case (r_cls)
          C_R, C_I:   w_next = WB_ALU;
          C_LW, C_SW: w_next = MEM;
          C_BR:       w_next = BRANCH;
          default:    w_next = HALT;
        endcase
      end
      MEM:      w_next = (r_cls == C_LW) ? WB_MEM : FETCH;
      WB_ALU:   w_next = FETCH;
      WB_MEM:   w_next = FETCH;
      BRANCH:   w_next = FETCH;
      HALT:     w_next = HALT;
      default:  w_next = RESET_ST;
    endcase
  end

  assign w_alu_ph = (r_state == EXEC)   ||
                    (r_state == MEM)    ||
                    (r_state == WB_ALU) ||
                    (r_state == WB_MEM);

  always_comb begin
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    pcsrc     = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    alusrc    = 1'b0;
    aluop     = 2'b00;
    regiwrite = 1'b0;
    memtoreg  = 1'b0;
    halted    = 1'b0;
    if (w_alu_ph) begin
      alusrc = (r_cls == C_I) || (r_cls == C_LW) || (r_cls == C_SW);
      unique case (r_cls)
        C_R:     aluop = 2'b10;
        C_I:     aluop = 2'b11;
        C_BR:    aluop = 2'b01;
        default: aluop = 2'b00;
      endcase
    end
    unique case (r_state)
      FETCH: irwrite = w_go;
      MEM: begin
        memread  = (r_cls == C_LW);
        memwrite = (r_cls == C_SW);
        pcwrite  = (r_cls == C_SW);
      end
      WB_ALU: begin
        regiwrite = 1'b1;
        pcwrite   = 1'b1;
      end
      WB_MEM: begin
        regiwrite = 1'b1;
        memtoreg  = 1'b1;
        pcwrite   = 1'b1;
      end
      BRANCH: begin
        pcwrite = 1'b1;
        unique case (r_f3)
          3'b000:  pcsrc = zero;
          3'b001:  pcsrc = ~zero;
          default: pcsrc = 1'b0;
        endcase
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign estado  = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: table, random and corner sequences.
// Counter narrowed to 4 bits so wrap-around is exercised.
module tb_controle_multiciclo;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
`ifdef CONTROLE_STEP_EN
  logic          step;
`endif
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          zero;
  logic [3:0]    estado;
  logic          irwrite;
  logic          pcwrite;
  logic          pcsrc;
  logic          memread;
  logic          memwrite;
  logic          alusrc;
  logic [1:0]    aluop;
  logic          regiwrite;
  logic          memtoreg;
  logic          halted;
  logic [CW-1:0] instret;

  int checks;
  int failures;
  int cnt;

  controle_multiciclo #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CONTROLE_STEP_EN
    .step      (step),
`endif
    .opcode    (opcode),
    .funct3    (funct3),
    .zero      (zero),
    .estado    (estado),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .pcsrc     (pcsrc),
    .memread   (memread),
    .memwrite  (memwrite),
    .alusrc    (alusrc),
    .aluop     (aluop),
    .regiwrite (regiwrite),
    .memtoreg  (memtoreg),
    .halted    (halted),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {estado, irw, pcw, pcsrc, mrd, mwr, alusrc, aluop, rw, m2r, halted}
  logic [14:0] w_vec;
  assign w_vec = {estado, irwrite, pcwrite, pcsrc, memread, memwrite,
                  alusrc, aluop, regiwrite, memtoreg, halted};

  typedef struct {
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             z;
    int               n;
    logic [4:0][14:0] v;
  } vec_t;

  vec_t tbl[6];

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  task automatic chk(input string name, input logic [14:0] got,
                     input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string name);
    logic [CW-1:0] e;
    e = CW'(cnt % (1 << CW));
    checks++;
    if (instret !== e) begin
      failures++;
      $display("FAIL %s: instret=%0d expected %0d at %0t",
               name, instret, e, $time);
    end
  endtask

  // Cycle k of one instruction, counted from its FETCH cycle.
  function automatic logic [14:0] model(input logic [6:0] op,
                                        input logic [2:0] f3,
                                        input int k, input logic z);
    logic [3:0] st;
    logic irw, pcw, pcs, mr, mw, as, rw, m2r;
    logic [1:0] aop;
    logic r, i, l, s, b;
    r = (op == OP_R); i = (op == OP_I); l = (op == OP_LW);
    s = (op == OP_SW); b = (op == OP_BR);
    st = 4'd0; irw = 0; pcw = 0; pcs = 0; mr = 0; mw = 0;
    as = 0; aop = 2'b00; rw = 0; m2r = 0;
    if (k == 0) begin
      st = 4'd1; irw = 1;
    end else if (k == 1) begin
      st = 4'd2;
    end else begin
      as  = i | l | s;
      aop = r ? 2'b10 : i ? 2'b11 : b ? 2'b01 : 2'b00;
      if (k == 2) begin
        st = 4'd3;
      end else if (r | i) begin
        st = 4'd5; rw = 1; pcw = 1;
      end else if (b) begin
        st = 4'd7; pcw = 1; as = 0; aop = 2'b00;
        pcs = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
      end else if (k == 3) begin
        st = 4'd4; mr = l; mw = s; pcw = s;
      end else begin
        st = 4'd6; rw = 1; m2r = 1; pcw = 1;
      end
    end
    return {st, irw, pcw, pcs, mr, mw, as, aop, rw, m2r, 1'b0};
  endfunction

  function automatic int ilen(input logic [6:0] op);
    return (op == OP_LW) ? 5 : 4;
  endfunction

  // Entered at posedge+1 with DUT in FETCH; leaves at posedge+1 of next FETCH.
  task automatic run_seq(input string name, input logic [6:0] op,
                         input logic [2:0] f3, input logic z, input int n,
                         input logic [4:0][14:0] v, input bit scr);
    for (int k = 0; k < n; k++) begin
      opcode = op;
      funct3 = f3;
      if (scr && k >= 2) begin
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
      end
      zero = z;
      #1;
      chk($sformatf("%s k%0d", name, k), w_vec, v[k]);
      if (k == 0) chk_cnt($sformatf("%s cnt", name));
      @(posedge clk);
      #1;
    end
    cnt++;
  endtask

  initial begin
    logic [4:0][14:0] v;
    logic [6:0] ops[5];
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    checks = 0; failures = 0; cnt = 0;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW;
    ops[3] = OP_SW; ops[4] = OP_BR;

    tbl[0] = '{OP_R, 3'd5, 1'b0, 4, {15'h0, {4'd5, 11'b01000010100},
               {4'd3, 11'b00000010000}, {4'd2, 11'b0}, {4'd1, 11'b10000000000}}};
    tbl[1] = '{OP_LW, 3'd2, 1'b0, 5, {{4'd6, 11'b01000100110},
               {4'd4, 11'b00010100000}, {4'd3, 11'b00000100000},
               {4'd2, 11'b0}, {4'd1, 11'b10000000000}}};
    tbl[2] = '{OP_SW, 3'd2, 1'b1, 4, {15'h0, {4'd4, 11'b01001100000},
               {4'd3, 11'b00000100000}, {4'd2, 11'b0}, {4'd1, 11'b10000000000}}};
    tbl[3] = '{OP_BR, 3'd0, 1'b1, 4, {15'h0, {4'd7, 11'b01100000000},
               {4'd3, 11'b00000001000}, {4'd2, 11'b0}, {4'd1, 11'b10000000000}}};
    tbl[4] = '{OP_BR, 3'd1, 1'b1, 4, {15'h0, {4'd7, 11'b01000000000},
               {4'd3, 11'b00000001000}, {4'd2, 11'b0}, {4'd1, 11'b10000000000}}};
    tbl[5] = '{OP_I, 3'd0, 1'b1, 4, {15'h0, {4'd5, 11'b01000111100},
               {4'd3, 11'b00000111000}, {4'd2, 11'b0}, {4'd1, 11'b10000000000}}};

    rst_n = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0;
`ifdef CONTROLE_STEP_EN
    step = 1'b1;
`endif
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    opcode = OP_R;
    chk("reset held", w_vec, 15'h0);
    chk_cnt("reset cnt");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_st", w_vec, 15'h0);
    @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++)
      run_seq($sformatf("tbl%0d", t), tbl[t].op, tbl[t].f3, tbl[t].z,
              tbl[t].n, tbl[t].v, 1'b0);

    for (int t = 0; t < 40; t++) begin
      op = ops[$urandom_range(0, 4)];
      f3 = (op == OP_BR) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      z  = 1'($urandom_range(0, 1));
      for (int k = 0; k < 5; k++) v[k] = model(op, f3, k, z);
      run_seq($sformatf("rnd%0d", t), op, f3, z, ilen(op), v, 1'b1);
    end
    chk_cnt("after random");

    opcode = OP_R; funct3 = 3'd0; zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rstwb k%0d", k), w_vec, model(OP_R, 3'd0, k, 1'b0));
      @(posedge clk);
      #1;
    end
    #1;
    chk("rstwb wb_alu", w_vec, model(OP_R, 3'd0, 3, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    cnt = 0;
    chk("rstwb async", w_vec, 15'h0);
    chk_cnt("rstwb cnt");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef CONTROLE_STEP_EN
    step = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("step hold %0d", k), w_vec, {4'd1, 11'b0});
      @(posedge clk);
      #1;
    end
    step = 1'b1;
    #1;
    chk("step pulse", w_vec, {4'd1, 11'b10000000000});
    @(posedge clk);
    #1;
    step = 1'b0;
    #1;
    chk("step decode", w_vec, {4'd2, 11'b0});
    @(posedge clk);
    #1;
    step = 1'b1;
    for (int k = 2; k < 4; k++) begin
      #1;
      chk($sformatf("step k%0d", k), w_vec, model(OP_R, 3'd0, k, 1'b0));
      @(posedge clk);
      #1;
    end
    cnt++;
`endif

    opcode = 7'b0000000;
    #1;
    chk("halt fetch", w_vec, model(7'd0, 3'd0, 0, 1'b0));
    @(posedge clk);
    #1;
    #1;
    chk("halt decode", w_vec, {4'd2, 11'b0});
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      opcode = ops[$urandom_range(0, 4)];
      #1;
      chk($sformatf("halted %0d", k), w_vec, {4'd8, 11'b00000000001});
      chk_cnt($sformatf("halt cnt %0d", k));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
